// File: rtl/rni_rlink.sv
// rni_rlink: AXI4 R-channel egress for the RNI.
// Keeps an in-order queue of accepted read bursts (ID, length) and pairs each
// with beats from the read-data buffer. It drives a registered R output stage.
// Optional feature macro: RNI_RLINK_ERR_STICKY_EN. When it is defined, RRESP
// carries the worst response seen so far in the current burst.
module rni_rlink #(
  parameter int ID_W      = 11,
  parameter int DATA_W    = 256,
  parameter int LEN_W     = 8,
  parameter int CMD_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  input  logic [ID_W-1:0]   cmd_id_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  output logic              cmd_ready_o,
  input  logic              dbuf_valid_i,
  input  logic [DATA_W-1:0] dbuf_data_i,
  input  logic [1:0]        dbuf_resp_i,
  output logic              dbuf_ready_o,
  output logic              RVALID,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  input  logic              RREADY,
  output logic              idle_o
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]   r_idMem  [CMD_DEPTH];
  logic [LEN_W-1:0]  r_lenMem [CMD_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic [LEN_W-1:0]  r_beatCnt;

  logic              r_rvalid;
  logic [ID_W-1:0]   r_rid;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic              r_rlast;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_ld;
  logic              w_xfer;
  logic              w_last;
  logic [ID_W-1:0]   w_headId;
  logic [LEN_W-1:0]  w_headLen;
  logic [1:0]        w_resp;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(CMD_DEPTH));
  assign w_headId  = r_idMem[r_rdPtr];
  assign w_headLen = r_lenMem[r_rdPtr];

  assign cmd_ready_o  = ~w_full;
  assign w_push       = cmd_valid_i & ~w_full;
  assign w_ld         = ~r_rvalid | RREADY;
  assign dbuf_ready_o = ~w_empty & w_ld;
  assign w_xfer       = dbuf_valid_i & dbuf_ready_o;
  assign w_last       = (r_beatCnt == w_headLen);
  assign w_pop        = w_xfer & w_last;

  assign RVALID = r_rvalid;
  assign RID    = r_rid;
  assign RDATA  = r_rdata;
  assign RRESP  = r_rresp;
  assign RLAST  = r_rlast;
  assign idle_o = w_empty & ~r_rvalid;

`ifdef RNI_RLINK_ERR_STICKY_EN
  logic [1:0] r_sticky;

  // Track the worst response of the burst; it restarts clean after the last beat
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sticky <= 2'b00;
    end else if (w_xfer) begin
      r_sticky <= w_last ? 2'b00 : w_resp;
    end
  end

  assign w_resp = (dbuf_resp_i > r_sticky) ? dbuf_resp_i : r_sticky;
`else
  assign w_resp = dbuf_resp_i;
`endif

  // Descriptor storage; contents need no reset because the count gates their use
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_idMem[r_wrPtr]  <= cmd_id_i;
      r_lenMem[r_wrPtr] <= cmd_len_i;
    end
  end

  // Queue pointers and fill count; a push and a pop together leave the count unchanged
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Beat position inside the head burst; it wraps to zero when the last beat leaves
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_beatCnt <= '0;
    end else if (w_xfer) begin
      r_beatCnt <= w_last ? '0 : r_beatCnt + LEN_W'(1);
    end
  end

  // Registered R stage: load on a transfer and drop valid when it drains with nothing new
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rvalid <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
      r_rlast  <= 1'b0;
    end else if (w_xfer) begin
      r_rvalid <= 1'b1;
      r_rid    <= w_headId;
      r_rdata  <= dbuf_data_i;
      r_rresp  <= w_resp;
      r_rlast  <= w_last;
    end else if (w_ld) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rni_rlink.sv
// tb_rni_rlink: directed self-checking bench for rni_rlink.
// Expected RRESP values follow RNI_RLINK_ERR_STICKY_EN when that macro is defined.
module tb_rni_rlink;

  localparam int ID_W   = 11;
  localparam int DATA_W = 256;
  localparam int LEN_W  = 8;

  logic              clk_i;
  logic              rst_i;
  logic              cmd_valid_i;
  logic [ID_W-1:0]   cmd_id_i;
  logic [LEN_W-1:0]  cmd_len_i;
  logic              cmd_ready_o;
  logic              dbuf_valid_i;
  logic [DATA_W-1:0] dbuf_data_i;
  logic [1:0]        dbuf_resp_i;
  logic              dbuf_ready_o;
  logic              RVALID;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RREADY;
  logic              idle_o;

  int checksPassed = 0;
  int checksTotal  = 0;

  logic [1:0] respIn     [5];
  logic [1:0] respExpect [5];

  rni_rlink #(.ID_W(ID_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .CMD_DEPTH(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_id_i     (cmd_id_i),
    .cmd_len_i    (cmd_len_i),
    .cmd_ready_o  (cmd_ready_o),
    .dbuf_valid_i (dbuf_valid_i),
    .dbuf_data_i  (dbuf_data_i),
    .dbuf_resp_i  (dbuf_resp_i),
    .dbuf_ready_o (dbuf_ready_o),
    .RVALID       (RVALID),
    .RID          (RID),
    .RDATA        (RDATA),
    .RRESP        (RRESP),
    .RLAST        (RLAST),
    .RREADY       (RREADY),
    .idle_o       (idle_o)
  );

  // Free-running clock, 10 time units per period
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [DATA_W-1:0] mkData(input int idx);
    return {8{32'hDA7A0000 + 32'(idx)}};
  endfunction

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pushCmd(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len);
    cmd_valid_i = 1'b1;
    cmd_id_i    = id;
    cmd_len_i   = len;
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic applyStimulus(input int dataIdx, input logic [1:0] resp);
    dbuf_valid_i = 1'b1;
    dbuf_data_i  = mkData(dataIdx);
    dbuf_resp_i  = resp;
  endtask

  task automatic checkBeat(input string tag, input logic [ID_W-1:0] id,
                           input logic last, input int dataIdx);
    checkOutput({tag, ".rvalid"}, DATA_W'(RVALID), DATA_W'(1'b1));
    checkOutput({tag, ".rid"},    DATA_W'(RID),    DATA_W'(id));
    checkOutput({tag, ".rlast"},  DATA_W'(RLAST),  DATA_W'(last));
    checkOutput({tag, ".rdata"},  RDATA,           mkData(dataIdx));
  endtask

  initial begin
    rst_i        = 1'b0;
    cmd_valid_i  = 1'b0;
    cmd_id_i     = '0;
    cmd_len_i    = '0;
    dbuf_valid_i = 1'b0;
    dbuf_data_i  = '0;
    dbuf_resp_i  = 2'b00;
    RREADY       = 1'b1;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst.rvalid",    DATA_W'(RVALID),       '0);
    checkOutput("rst.rlast",     DATA_W'(RLAST),        '0);
    checkOutput("rst.rid",       DATA_W'(RID),          '0);
    checkOutput("rst.rdata",     RDATA,                 '0);
    checkOutput("rst.rresp",     DATA_W'(RRESP),        '0);
    checkOutput("rst.cmdReady",  DATA_W'(cmd_ready_o),  DATA_W'(1'b1));
    checkOutput("rst.dbufReady", DATA_W'(dbuf_ready_o), '0);
    checkOutput("rst.idle",      DATA_W'(idle_o),       DATA_W'(1'b1));
    @(negedge clk_i);
    rst_i = 1'b1;
    step();

    // Single burst id=5 len=3, four beats back to back
    pushCmd(11'h5, 8'd3);
    applyStimulus(0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      step();
      checkBeat($sformatf("t1.b%0d", i), 11'h5, (i == 3), i);
      if (i < 3) applyStimulus(i + 1, 2'b00);
      else dbuf_valid_i = 1'b0;
    end
    step();
    checkOutput("t1.drained", DATA_W'(RVALID), '0);
    checkOutput("t1.idle",    DATA_W'(idle_o), DATA_W'(1'b1));
    applyStimulus(99, 2'b00);
    #1;
    checkOutput("t1.emptyNoReady", DATA_W'(dbuf_ready_o), '0);
    dbuf_valid_i = 1'b0;

    // Two bursts (1,len0) and (2,len1) across a burst boundary with no bubble
    pushCmd(11'h1, 8'd0);
    pushCmd(11'h2, 8'd1);
    applyStimulus(4, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step();
      checkBeat($sformatf("t2.b%0d", i), (i == 0) ? 11'h1 : 11'h2, (i != 1), 4 + i);
      if (i < 2) applyStimulus(5 + i, 2'b00);
      else dbuf_valid_i = 1'b0;
    end
    step();
    checkOutput("t2.idle", DATA_W'(idle_o), DATA_W'(1'b1));

    // RREADY back-pressure 1,0,0,1 during a four-beat burst
    pushCmd(11'h7, 8'd3);
    applyStimulus(10, 2'b00);
    RREADY = 1'b1;
    step();
    checkBeat("t3.b0", 11'h7, 1'b0, 10);
    applyStimulus(11, 2'b00);
    RREADY = 1'b0;
    #1;
    checkOutput("t3.stallRdy0", DATA_W'(dbuf_ready_o), '0);
    step();
    checkBeat("t3.hold1", 11'h7, 1'b0, 10);
    checkOutput("t3.stallRdy1", DATA_W'(dbuf_ready_o), '0);
    step();
    checkBeat("t3.hold2", 11'h7, 1'b0, 10);
    RREADY = 1'b1;
    #1;
    checkOutput("t3.resumeRdy", DATA_W'(dbuf_ready_o), DATA_W'(1'b1));
    step();
    checkBeat("t3.b1", 11'h7, 1'b0, 11);
    applyStimulus(12, 2'b00);
    step();
    checkBeat("t3.b2", 11'h7, 1'b0, 12);
    applyStimulus(13, 2'b00);
    step();
    checkBeat("t3.b3", 11'h7, 1'b1, 13);
    dbuf_valid_i = 1'b0;
    step();
    checkOutput("t3.drained", DATA_W'(RVALID), '0);

    // Fill the queue, then keep a push pending while the head burst drains
    pushCmd(11'h8, 8'd1);
    pushCmd(11'h9, 8'd0);
    pushCmd(11'hA, 8'd0);
    pushCmd(11'hB, 8'd0);
    checkOutput("t4.fullReady", DATA_W'(cmd_ready_o), '0);
    cmd_valid_i = 1'b1;
    cmd_id_i    = 11'hC;
    cmd_len_i   = 8'd0;
    applyStimulus(30, 2'b00);
    step();
    checkBeat("t4.b0", 11'h8, 1'b0, 30);
    checkOutput("t4.stillFull", DATA_W'(cmd_ready_o), '0);
    applyStimulus(31, 2'b00);
    step();
    checkBeat("t4.b1", 11'h8, 1'b1, 31);
    checkOutput("t4.afterPop", DATA_W'(cmd_ready_o), DATA_W'(1'b1));
    applyStimulus(32, 2'b00);
    step();
    checkBeat("t4.b2", 11'h9, 1'b1, 32);
    checkOutput("t4.pushPop", DATA_W'(cmd_ready_o), DATA_W'(1'b1));
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(33 + i, 2'b00);
      step();
      checkBeat($sformatf("t4.d%0d", i), 11'hA + 11'(i), 1'b1, 33 + i);
    end
    dbuf_valid_i = 1'b0;
    step();
    checkOutput("t4.idle", DATA_W'(idle_o), DATA_W'(1'b1));

    // Response handling: burst (3,len3) with OKAY,SLVERR,OKAY,OKAY then burst (4,len0)
    respIn = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
`ifdef RNI_RLINK_ERR_STICKY_EN
    respExpect = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
`else
    respExpect = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
`endif
    pushCmd(11'h3, 8'd3);
    pushCmd(11'h4, 8'd0);
    applyStimulus(20, respIn[0]);
    for (int i = 0; i < 5; i++) begin
      step();
      checkBeat($sformatf("t5.b%0d", i), (i < 4) ? 11'h3 : 11'h4, (i >= 3), 20 + i);
      checkOutput($sformatf("t5.rresp%0d", i), DATA_W'(RRESP), DATA_W'(respExpect[i]));
      if (i < 4) applyStimulus(21 + i, respIn[i + 1]);
      else dbuf_valid_i = 1'b0;
    end
    step();

    // Asynchronous reset in the middle of a four-beat burst
    pushCmd(11'h6, 8'd3);
    applyStimulus(40, 2'b00);
    step();
    applyStimulus(41, 2'b00);
    step();
    checkBeat("t6.b1", 11'h6, 1'b0, 41);
    dbuf_valid_i = 1'b0;
    rst_i = 1'b0;
    #1;
    checkOutput("t6.rvalid",   DATA_W'(RVALID),      '0);
    checkOutput("t6.cmdReady", DATA_W'(cmd_ready_o), DATA_W'(1'b1));
    checkOutput("t6.idle",     DATA_W'(idle_o),      DATA_W'(1'b1));
    @(negedge clk_i);
    rst_i = 1'b1;
    pushCmd(11'hD, 8'd1);
    applyStimulus(50, 2'b00);
    step();
    checkBeat("t6.n0", 11'hD, 1'b0, 50);
    applyStimulus(51, 2'b00);
    step();
    checkBeat("t6.n1", 11'hD, 1'b1, 51);
    dbuf_valid_i = 1'b0;
    step();
    checkOutput("t6.idleEnd", DATA_W'(idle_o), DATA_W'(1'b1));

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
